byte_queue: RTL

- Circular FIFO directly downstream of the serial-to-parallel deserializer stage.
- Accepts each assembled byte over a four-phase data_ready/ack handshake and buffers up to DEPTH bytes.
- Releases bytes one per dequeue request to the downstream consumer.
- Reports occupancy, full and empty.

---
 rtl/byte_queue_pkg.sv | 15 +
 rtl/byte_queue_mem.sv | 30 +++
 rtl/byte_queue.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/byte_queue_pkg.sv
// byte_queue_pkg: shared types and default sizes for the byte queue that
// sits behind the serial-to-parallel deserializer.
package byte_queue_pkg;

    // Enqueue handshake states: waiting for a byte, or holding ack until
    // the deserializer withdraws data_ready.
    typedef enum logic {
        Q_IDLE,
        Q_ACK
    } q_state_t;

    localparam int QUEUE_DATA_W = 8;
    localparam int QUEUE_DEPTH  = 8;

endpackage : byte_queue_pkg

// File: rtl/byte_queue_mem.sv
// byte_queue_mem: DEPTH x DATA_W register array with one synchronous write
// port and one combinational read port. Contents are never reset; the
// pointers and count in the parent decide which entries are meaningful.
module byte_queue_mem
    import byte_queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int DEPTH  = QUEUE_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming byte at the write address when enabled.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : byte_queue_mem

// File: rtl/byte_queue.sv
// byte_queue: circular FIFO fed by the deserializer over a four-phase
// data_ready/ack handshake and drained one byte per dequeue request.
// Optional macro BYTE_QUEUE_ALMOST_FULL_EN adds almost_full_out, which is
// high whenever occupancy is DEPTH-1 or more.
module byte_queue
    import byte_queue_pkg::*;
#(
    parameter int DATA_W = QUEUE_DATA_W,
    parameter int DEPTH  = QUEUE_DEPTH,
    localparam int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_ready_in,
    output logic              ack_out,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
`ifdef BYTE_QUEUE_ALMOST_FULL_EN
    output logic              empty_out,
    output logic              almost_full_out
`else
    output logic              empty_out
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    q_state_t          state;
    q_state_t          next_state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  len;
    logic              do_write;
    logic              do_read;
    logic [DATA_W-1:0] rdata;

    byte_queue_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (do_write),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Status flags come straight from the registered count so they always
    // agree with len_out and reflect the pre-edge state for the next edge.
    assign len_out   = len;
    assign full_out  = (len == LEN_FULL);
    assign empty_out = (len == '0);

`ifdef BYTE_QUEUE_ALMOST_FULL_EN
    assign almost_full_out = (len >= LEN_W'(DEPTH - 1));
`endif

    // Ack is high for exactly as long as the FSM sits in Q_ACK, so it rises
    // the cycle after the write and drops with reset asynchronously.
    assign ack_out = (state == Q_ACK);

    // A dequeue only takes effect when something is stored; no bypass.
    assign do_read = dequeue_in && !empty_out;

    // Handshake state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= Q_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and write decision: a write happens only on entry to Q_ACK,
    // so one handshake produces exactly one entry; full blocks the write
    // even if a dequeue frees a slot on the same edge.
    always_comb begin
        next_state = state;
        do_write   = 1'b0;
        case (state)
            Q_IDLE: begin
                if (data_ready_in && !full_out) begin
                    do_write   = 1'b1;
                    next_state = Q_ACK;
                end
            end
            Q_ACK: begin
                if (!data_ready_in) begin
                    next_state = Q_IDLE;
                end
            end
            default: begin
                next_state = Q_IDLE;
            end
        endcase
    end

    // Pointers advance independently and wrap naturally since DEPTH is a
    // power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Occupancy count: simultaneous write and read cancel out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len <= '0;
        end else begin
            case ({do_write, do_read})
                2'b10:   len <= len + LEN_ONE;
                2'b01:   len <= len - LEN_ONE;
                default: len <= len;
            endcase
        end
    end

    // Output register: capture the head byte on a successful dequeue and
    // pulse data_valid_out for that single cycle; otherwise hold data_out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out       <= '0;
            data_valid_out <= 1'b0;
        end else begin
            data_valid_out <= do_read;
            if (do_read) begin
                data_out <= rdata;
            end
        end
    end

endmodule : byte_queue
